// File: rtl/hit_response_fsm.sv
// Hit response controller for one fighter: registers opponent hits, accumulates
// damage, and sequences hitstun, then invulnerability, then idle, all on game-frame ticks.
module hit_response_fsm #(
  parameter int STUN_BASE     = 8,
  parameter int INVULN_FRAMES = 20,
  parameter int DMG_MAX       = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       opp_attack_active,
  input  logic [3:0] opp_anim_state,
  input  logic       hitbox_overlap,
  input  logic       opp_facing_left,
  input  logic       damage_clear,
  output logic       hit_stun_active,
  output logic       invuln_active,
  output logic       hit_pulse,
  output logic [7:0] damage_pct,
  output logic [5:0] knockback_vx,
  output logic [5:0] knockback_vy,
  output logic [3:0] anim_state
);

  localparam int TIMER_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HITSTUN = 2'd1,
    INVULN  = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [TIMER_W-1:0] timer, timer_next;
  logic               consumed, consumed_next;
  logic [7:0]         damage_next;
  logic [5:0]         vx_next, vy_next;
  logic               pulse_next;

  logic               code_valid;
  logic [3:0]         dmg_amt;
  logic [7:0]         dmg_base;
  logic [8:0]         dmg_sum;
  logic [7:0]         dmg_new;
  logic [3:0]         mag;
  logic signed [5:0]  mag_s, half_s;
  logic signed [5:0]  hit_vx, hit_vy;
  logic [TIMER_W-1:0] stun_len;
  logic               hit;

  always_comb begin
    code_valid = 1'b1;
    dmg_amt    = 4'd0;
    case (opp_anim_state)
      4'd6:    dmg_amt = 4'd3;
      4'd7:    dmg_amt = 4'd5;
      4'd8:    dmg_amt = 4'd4;
      4'd9:    dmg_amt = 4'd6;
      default: code_valid = 1'b0;
    endcase
  end

  // A clear on the hit tick means the new hit starts from zero damage.
  assign dmg_base = damage_clear ? 8'd0 : damage_pct;
  assign dmg_sum  = {1'b0, dmg_base} + {5'b0_0000, dmg_amt};
  assign dmg_new  = (dmg_sum > 9'(DMG_MAX)) ? 8'(DMG_MAX) : dmg_sum[7:0];

  assign stun_len = TIMER_W'(STUN_BASE) + TIMER_W'(dmg_new[7:4]);
  assign mag      = 4'd2 + {1'b0, dmg_new[7:5]};
  assign mag_s    = {2'b00, mag};
  assign half_s   = {3'b000, mag[3:1]};

  always_comb begin
    hit_vx = 6'sd0;
    hit_vy = 6'sd0;
    case (opp_anim_state)
      4'd6: begin
        hit_vx = opp_facing_left ? -half_s : half_s;
        hit_vy = 6'sd1;
      end
      4'd7: begin
        hit_vx = opp_facing_left ? -mag_s : mag_s;
        hit_vy = 6'sd1;
      end
      4'd8: begin
        hit_vx = 6'sd0;
        hit_vy = mag_s;
      end
      4'd9: begin
        hit_vx = opp_facing_left ? -6'sd1 : 6'sd1;
        hit_vy = -mag_s;
      end
      default: begin
        hit_vx = 6'sd0;
        hit_vy = 6'sd0;
      end
    endcase
  end

  assign hit = frame_tick && (state == IDLE) && opp_attack_active &&
               hitbox_overlap && code_valid && !consumed;

  always_comb begin
    state_next    = state;
    timer_next    = timer;
    consumed_next = consumed;
    damage_next   = damage_pct;
    vx_next       = knockback_vx;
    vy_next       = knockback_vy;
    pulse_next    = hit;

    if (frame_tick) begin
      // The latch keeps one opponent swing from landing more than once.
      if (opp_attack_active && hitbox_overlap)
        consumed_next = 1'b1;
      else if (!opp_attack_active)
        consumed_next = 1'b0;

      if (damage_clear)
        damage_next = 8'd0;

      case (state)
        IDLE: begin
          if (hit) begin
            state_next  = HITSTUN;
            timer_next  = stun_len;
            damage_next = dmg_new;
            vx_next     = hit_vx;
            vy_next     = hit_vy;
          end
        end
        HITSTUN: begin
          if (timer == TIMER_W'(1)) begin
            state_next = INVULN;
            timer_next = TIMER_W'(INVULN_FRAMES);
            vx_next    = 6'd0;
            vy_next    = 6'd0;
          end else begin
            timer_next = timer - TIMER_W'(1);
          end
        end
        INVULN: begin
          if (timer == TIMER_W'(1)) begin
            state_next = IDLE;
            timer_next = '0;
          end else begin
            timer_next = timer - TIMER_W'(1);
          end
        end
        default: begin
          state_next = IDLE;
          timer_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      timer        <= '0;
      consumed     <= 1'b0;
      damage_pct   <= 8'd0;
      knockback_vx <= 6'd0;
      knockback_vy <= 6'd0;
      hit_pulse    <= 1'b0;
    end else begin
      state        <= state_next;
      timer        <= timer_next;
      consumed     <= consumed_next;
      damage_pct   <= damage_next;
      knockback_vx <= vx_next;
      knockback_vy <= vy_next;
      hit_pulse    <= pulse_next;
    end
  end

  assign hit_stun_active = (state == HITSTUN);
  assign invuln_active   = (state == INVULN);
  assign anim_state      = (state == HITSTUN) ? 4'd10 : 4'd0;

endmodule

// File: tb/tb_hit_response_fsm.sv
// Directed bench for hit_response_fsm: frame ticks every other clock,
// expected values hand-computed from the damage/stun/knockback rules.
module tb_hit_response_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic       opp_attack_active;
  logic [3:0] opp_anim_state;
  logic       hitbox_overlap;
  logic       opp_facing_left;
  logic       damage_clear;
  logic       hit_stun_active;
  logic       invuln_active;
  logic       hit_pulse;
  logic [7:0] damage_pct;
  logic [5:0] knockback_vx;
  logic [5:0] knockback_vy;
  logic [3:0] anim_state;

  int check_count = 0;
  int error_count = 0;
  int n;

  hit_response_fsm dut (
    .clk               (clk),
    .reset             (reset),
    .frame_tick        (frame_tick),
    .opp_attack_active (opp_attack_active),
    .opp_anim_state    (opp_anim_state),
    .hitbox_overlap    (hitbox_overlap),
    .opp_facing_left   (opp_facing_left),
    .damage_clear      (damage_clear),
    .hit_stun_active   (hit_stun_active),
    .invuln_active     (invuln_active),
    .hit_pulse         (hit_pulse),
    .damage_pct        (damage_pct),
    .knockback_vx      (knockback_vx),
    .knockback_vy      (knockback_vy),
    .anim_state        (anim_state)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // One frame tick spanning a single rising edge; outputs are stable on return.
  task automatic applyStimulus(input logic act, input logic [3:0] code, input logic ovl,
                               input logic left, input logic clr);
    @(negedge clk);
    opp_attack_active = act;
    opp_anim_state    = code;
    hitbox_overlap    = ovl;
    opp_facing_left   = left;
    damage_clear      = clr;
    frame_tick        = 1'b1;
    @(negedge clk);
    frame_tick   = 1'b0;
    damage_clear = 1'b0;
  endtask

  task automatic quietTick();
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic waitIdle(input string tag);
    int k = 0;
    while ((hit_stun_active || invuln_active) && k < 100) begin
      quietTick();
      k++;
    end
    checkOutput(tag, int'(hit_stun_active || invuln_active), 0);
  endtask

  task automatic doHit(input logic [3:0] code);
    applyStimulus(1'b1, code, 1'b1, 1'b0, 1'b0);
    waitIdle("hit_settle");
  endtask

  task automatic countTicks(input bit want_stun, output int cnt);
    cnt = 0;
    while ((want_stun ? hit_stun_active : invuln_active) && cnt < 100) begin
      quietTick();
      cnt++;
    end
  endtask

  task automatic checkZero(input string tag);
    checkOutput({tag, "_stun"},   int'(hit_stun_active), 0);
    checkOutput({tag, "_invuln"}, int'(invuln_active), 0);
    checkOutput({tag, "_pulse"},  int'(hit_pulse), 0);
    checkOutput({tag, "_damage"}, int'(damage_pct), 0);
    checkOutput({tag, "_vx"},     int'($signed(knockback_vx)), 0);
    checkOutput({tag, "_vy"},     int'($signed(knockback_vy)), 0);
    checkOutput({tag, "_anim"},   int'(anim_state), 0);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int codes[4] = '{0, 5, 10, 15};

    reset = 1'b1;
    frame_tick = 1'b0;
    opp_attack_active = 1'b0;
    opp_anim_state = 4'd0;
    hitbox_overlap = 1'b0;
    opp_facing_left = 1'b0;
    damage_clear = 1'b0;
    repeat (2) @(negedge clk);
    checkZero("reset");
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] side hit from zero damage");
    applyStimulus(1'b1, 4'd7, 1'b1, 1'b0, 1'b0);
    checkOutput("side_pulse",  int'(hit_pulse), 1);
    checkOutput("side_damage", int'(damage_pct), 5);
    checkOutput("side_vx",     int'($signed(knockback_vx)), 2);
    checkOutput("side_vy",     int'($signed(knockback_vy)), 1);
    checkOutput("side_stun",   int'(hit_stun_active), 1);
    checkOutput("side_anim",   int'(anim_state), 10);
    @(negedge clk);
    checkOutput("side_pulse_drop", int'(hit_pulse), 0);
    checkOutput("side_stun_hold",  int'(hit_stun_active), 1);
    countTicks(1'b1, n);
    checkOutput("side_stun_ticks", n, 8);
    checkOutput("side_invuln", int'(invuln_active), 1);
    checkOutput("side_inv_vx", int'($signed(knockback_vx)), 0);
    checkOutput("side_inv_vy", int'($signed(knockback_vy)), 0);
    checkOutput("side_inv_anim", int'(anim_state), 0);
    countTicks(1'b0, n);
    checkOutput("side_invuln_ticks", n, 20);
    checkOutput("side_idle_stun", int'(hit_stun_active), 0);
    checkOutput("side_idle_damage", int'(damage_pct), 5);

    $display("[TB] building damage to 253, then down hit at saturation");
    repeat (40) doHit(4'd9);
    repeat (2) doHit(4'd8);
    checkOutput("pre_sat_damage", int'(damage_pct), 253);
    applyStimulus(1'b1, 4'd9, 1'b1, 1'b1, 1'b0);
    checkOutput("sat_pulse",  int'(hit_pulse), 1);
    checkOutput("sat_damage", int'(damage_pct), 255);
    checkOutput("sat_vx",     int'($signed(knockback_vx)), -1);
    checkOutput("sat_vy",     int'($signed(knockback_vy)), -9);
    countTicks(1'b1, n);
    checkOutput("sat_stun_ticks", n, 23);
    waitIdle("sat_settle");

    $display("[TB] single hit per attack with overlap held");
    applyStimulus(1'b1, 4'd8, 1'b1, 1'b0, 1'b0);
    checkOutput("hold_pulse",  int'(hit_pulse), 1);
    checkOutput("hold_vx",     int'($signed(knockback_vx)), 0);
    checkOutput("hold_vy",     int'($signed(knockback_vy)), 9);
    checkOutput("hold_damage", int'(damage_pct), 255);
    n = 0;
    while ((hit_stun_active || invuln_active) && n < 100) begin
      applyStimulus(1'b1, 4'd8, 1'b1, 1'b0, 1'b0);
      n++;
    end
    checkOutput("hold_busy_ticks", n, 43);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 4'd8, 1'b1, 1'b0, 1'b0);
      checkOutput("hold_no_rehit_pulse", int'(hit_pulse), 0);
      checkOutput("hold_no_rehit_stun",  int'(hit_stun_active), 0);
    end
    applyStimulus(1'b0, 4'd8, 1'b1, 1'b0, 1'b0);
    checkOutput("drop_stun", int'(hit_stun_active), 0);
    applyStimulus(1'b1, 4'd8, 1'b1, 1'b0, 1'b0);
    checkOutput("reattack_pulse", int'(hit_pulse), 1);
    checkOutput("reattack_stun",  int'(hit_stun_active), 1);
    waitIdle("reattack_settle");

    $display("[TB] invalid attack codes");
    foreach (codes[i]) begin
      applyStimulus(1'b1, 4'(codes[i]), 1'b1, 1'b0, 1'b0);
      checkOutput("invalid_pulse", int'(hit_pulse), 0);
      checkOutput("invalid_stun",  int'(hit_stun_active), 0);
      checkOutput("invalid_vx",    int'($signed(knockback_vx)), 0);
      checkOutput("invalid_anim",  int'(anim_state), 0);
      quietTick();
    end
    checkOutput("invalid_damage", int'(damage_pct), 255);

    $display("[TB] damage_clear together with a neutral hit");
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("clear_damage", int'(damage_pct), 0);
    repeat (16) doHit(4'd9);
    doHit(4'd8);
    checkOutput("pre_clear_damage", int'(damage_pct), 100);
    applyStimulus(1'b1, 4'd6, 1'b1, 1'b1, 1'b1);
    checkOutput("clrhit_pulse",  int'(hit_pulse), 1);
    checkOutput("clrhit_damage", int'(damage_pct), 3);
    checkOutput("clrhit_vx",     int'($signed(knockback_vx)), -1);
    checkOutput("clrhit_vy",     int'($signed(knockback_vy)), 1);
    countTicks(1'b1, n);
    checkOutput("clrhit_stun_ticks", n, 8);
    repeat (19) quietTick();
    checkOutput("inv_last_tick_pending", int'(invuln_active), 1);
    applyStimulus(1'b1, 4'd7, 1'b1, 1'b0, 1'b0);
    checkOutput("inv_end_pulse",  int'(hit_pulse), 0);
    checkOutput("inv_end_stun",   int'(hit_stun_active), 0);
    checkOutput("inv_end_invuln", int'(invuln_active), 0);
    checkOutput("inv_end_damage", int'(damage_pct), 3);
    quietTick();

    $display("[TB] reset during hitstun");
    applyStimulus(1'b1, 4'd7, 1'b1, 1'b0, 1'b0);
    checkOutput("prereset_damage", int'(damage_pct), 8);
    repeat (3) quietTick();
    checkOutput("prereset_stun", int'(hit_stun_active), 1);
    @(negedge clk);
    frame_tick = 1'b1;
    reset = 1'b1;
    #1;
    checkZero("reset_mid");
    frame_tick = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b1, 4'd7, 1'b1, 1'b0, 1'b0);
    checkOutput("post_reset_pulse",  int'(hit_pulse), 1);
    checkOutput("post_reset_damage", int'(damage_pct), 5);
    checkOutput("post_reset_vx",     int'($signed(knockback_vx)), 2);
    checkOutput("post_reset_stun",   int'(hit_stun_active), 1);
    waitIdle("post_reset_settle");

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/hit_response_fsm.md
HIT_RESPONSE_FSM -- requirements
Module: hit_response_fsm

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): STUN_BASE, 8, base hitstun length in frames; INVULN_FRAMES, 20, post-stun invulnerability length in frames; DMG_MAX, 255, damage saturation value.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- frame_tick  in  1  one-clk pulse per game frame.
- opp_attack_active  in  1  opponent attack in progress.
- opp_anim_state  in  4  opponent attack code: 6 neutral, 7 side, 8 up, 9 down.
- hitbox_overlap  in  1  opponent hitbox overlaps own hurtbox.
- opp_facing_left  in  1  opponent faces -x; sets knockback x sign.
- damage_clear  in  1  stock lost; zero accumulated damage.
- hit_stun_active  out  1  high in HITSTUN.
- invuln_active  out  1  high in INVULN.
- hit_pulse  out  1  one-clk pulse on hit registration.
- damage_pct  out  8  accumulated damage, unsigned.
- knockback_vx  out  6  signed two's complement; +x is right.
- knockback_vy  out  6  signed two's complement; + is up.
- anim_state  out  4  10 in HITSTUN, else 0.

Function
REQ-003 The block SHALL update state, timer, damage and the latch only on clk edges where frame_tick=1; hit_pulse is the only exception.
REQ-004 The block SHALL implement three states: IDLE, HITSTUN and INVULN.
REQ-005 A hit SHALL be registered when all of the following hold on a tick: state IDLE; opp_attack_active=1; hitbox_overlap=1; opp_anim_state in 6..9; consumed latch=0.
REQ-006 An opp_anim_state outside 6..9 SHALL never register a hit.
REQ-007 The consumed latch SHALL set on any tick, in any state, where opp_attack_active=1 and hitbox_overlap=1.
REQ-008 The consumed latch SHALL clear on any tick where opp_attack_active=0, so that one opponent attack registers at most one hit.
REQ-009 Per-type damage SHALL be: neutral 3, side 5, up 4, down 6.
REQ-010 The new damage SHALL be min(damage_pct + dmg, DMG_MAX), computed with a 9-bit intermediate.
REQ-011 Hitstun length SHALL be STUN_BASE + (new damage >> 4) frames, giving a range of 8 to 23 frames.
REQ-012 Knockback magnitude SHALL be mag = 2 + (new damage >> 5), giving a range of 2 to 9.
REQ-013 The sign s SHALL be -1 if opp_facing_left=1, else +1.
REQ-014 Knockback vectors SHALL be: neutral vx=s*(mag>>1), vy=+1; side vx=s*mag, vy=+1; up vx=0, vy=+mag; down vx=s*1, vy=-mag.
REQ-015 On hit registration, the block SHALL, on the same edge: enter HITSTUN; load the timer with the stun length; latch damage_pct, knockback_vx and knockback_vy; and pulse hit_pulse high for exactly that one clk.
REQ-016 In HITSTUN, each tick SHALL decrement the timer.
REQ-017 On a tick in HITSTUN with timer=1, the block SHALL enter INVULN, load the timer with INVULN_FRAMES, and set knockback_vx and knockback_vy to 0.
REQ-018 hit_stun_active SHALL be high for exactly the stun-length number of ticks.
REQ-019 In INVULN, each tick SHALL decrement the timer; at timer=1 the block SHALL return to IDLE.
REQ-020 hitbox_overlap SHALL be ignored in HITSTUN and INVULN, except for its effect on the latch.
REQ-021 knockback_vx and knockback_vy SHALL hold their latched values throughout HITSTUN and be 0 in IDLE and INVULN.
REQ-022 When damage_clear=1 on a tick, damage_pct SHALL become 0; if a hit registers on the same tick, damage_pct SHALL become dmg, and stun length and mag SHALL be computed from that value.
REQ-023 damage_clear SHALL NOT change state or timer.
REQ-024 A hit on the very tick that INVULN ends SHALL NOT register; the earliest registrable tick is the first tick in IDLE.

Reset
REQ-025 While reset is asserted, the block SHALL force state IDLE, timer 0, latch 0, and all outputs 0, asynchronously.
REQ-026 Assertion of reset mid-HITSTUN or mid-INVULN SHALL abort immediately with no residual pulse.
REQ-027 After reset release, the first tick SHALL be evaluated from IDLE.

Verification
REQ-028 The bench SHALL cover the following directed scenarios:
- Side hit: damage 0, opp_anim_state 7, facing_left=0, overlap -> hit_pulse 1 clk; damage 5; vx=+2, vy=+1; stun high 8 ticks; invuln high 20 ticks; then IDLE.
- Down hit at saturation: damage 253, opp_anim_state 9, facing_left=1 -> damage 255; vx=-1, vy=-9; stun 23 ticks.
- Single hit per attack: overlap held through stun and invuln while opp_attack_active stays 1 -> no second hit. Drop opp_attack_active for 1 tick, then re-attack -> hit registers.
- Invalid code: opp_anim_state 0 with active and overlap -> no hit; all outputs stay 0.
- damage_clear with hit on the same tick at damage 100, neutral -> damage 3; vx=±1; stun 8.
- Reset asserted on the 4th stun tick -> all outputs 0 immediately. Hit on the first tick after release -> registers.
